fifo_flex: RTL and testbench

Parametrised synchronous FIFO, the successor to the lab FIFO. It adds:
- true full/empty detection for any power-of-two depth, using wrap-bit pointers
- an occupancy count
- programmable almost-full and almost-empty thresholds
- a selectable first-word-fall-through (FWFT) read mode

It sits between producers and consumers in one clock domain, for example as the UART RX/TX buffer and the memory-controller command queue.

---
 rtl/fifo_flex_pkg.sv | 13 +
 rtl/fifo_flex_mem.sv | 28 ++
 rtl/fifo_flex.sv | 107 ++++++++++
 tb/tb_fifo_flex.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg: shared helpers for the fifo_flex FIFO.
// Provides the pointer-width function and the read-mode constants.
package fifo_flex_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Pointers carry one extra wrap bit above the index bits.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// fifo_flex_mem: DEPTH x WIDTH storage, synchronous write and asynchronous read.
// Contents are deliberately not reset; the FIFO pointers define which entries are valid.
module fifo_flex_mem
   import fifo_flex_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32,
   parameter int AW    = ptr_w(DEPTH) - 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: synchronous FIFO with wrap-bit pointers, occupancy count, thresholds and FWFT mode.
// Define FIFO_FLEX_ERR_EN to add sticky overflow/underflow flags.
module fifo_flex
   import fifo_flex_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 32,
   parameter int FWFT      = FIFO_MODE_STD,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       din,
   output logic                   full,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count
`ifdef FIFO_FLEX_ERR_EN
   ,
   output logic                   overflow,
   output logic                   underflow
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_accept;
   logic             rd_accept;
   logic [WIDTH-1:0] rd_data;

   // Flags and count come only from the registered pointers, never from the requests.
   assign empty        = (wr_ptr == rd_ptr);
   assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count        = wr_ptr - rd_ptr;
   assign almost_full  = (count >= PW'(AF_THRESH));
   assign almost_empty = (count <= PW'(AE_THRESH));

   assign wr_accept = wr_en && !full;
   assign rd_accept = rd_en && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   fifo_flex_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_accept),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (din),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         // Head word shows through directly; forced to zero while empty so reset reads 0.
         assign dout = empty ? '0 : rd_data;
      end else begin : g_std
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dout <= '0;
            end else if (rd_accept) begin
               dout <= rd_data;
            end
         end
      end
   endgenerate

`ifdef FIFO_FLEX_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: self-checking bench for fifo_flex, one standard-mode and one FWFT instance.
// Queue models run alongside; a negedge process compares every cycle, directed checks pin literals.
module tb_fifo_flex;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;

   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] din   = '0;
   logic       full, almost_full, empty, almost_empty;
   logic [7:0] dout;
   logic [5:0] count;

   logic       wr_en_f = 1'b0;
   logic       rd_en_f = 1'b0;
   logic [7:0] din_f   = '0;
   logic       full_f, almost_full_f, empty_f, almost_empty_f;
   logic [7:0] dout_f;
   logic [5:0] count_f;

`ifdef FIFO_FLEX_ERR_EN
   logic overflow, underflow, overflow_f, underflow_f;
`endif

   int checks   = 0;
   int failures = 0;
   int max_count;

   always #5 clk = ~clk;

   fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .din          (din),
      .full         (full),
      .almost_full  (almost_full),
      .rd_en        (rd_en),
      .dout         (dout),
      .empty        (empty),
      .almost_empty (almost_empty),
      .count        (count)
`ifdef FIFO_FLEX_ERR_EN
      ,
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en_f),
      .din          (din_f),
      .full         (full_f),
      .almost_full  (almost_full_f),
      .rd_en        (rd_en_f),
      .dout         (dout_f),
      .empty        (empty_f),
      .almost_empty (almost_empty_f),
      .count        (count_f)
`ifdef FIFO_FLEX_ERR_EN
      ,
      .overflow     (overflow_f),
      .underflow    (underflow_f)
`endif
   );

   // Reference models: a queue of stored words, the last popped word, sticky error bits.
   logic [7:0] q   [$];
   logic [7:0] q_f [$];
   logic [7:0] m_dout;
   bit         m_ovf, m_udf, m_ovf_f, m_udf_f;
   bit         w_ok, r_ok, w_ok_f, r_ok_f;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         q_f.delete();
         m_dout  = '0;
         m_ovf   = 0;
         m_udf   = 0;
         m_ovf_f = 0;
         m_udf_f = 0;
      end else begin
         w_ok = wr_en && (q.size() < DEPTH);
         r_ok = rd_en && (q.size() > 0);
         if (wr_en && q.size() == DEPTH) m_ovf = 1;
         if (rd_en && q.size() == 0) m_udf = 1;
         if (r_ok) m_dout = q.pop_front();
         if (w_ok) q.push_back(din);

         w_ok_f = wr_en_f && (q_f.size() < DEPTH);
         r_ok_f = rd_en_f && (q_f.size() > 0);
         if (wr_en_f && q_f.size() == DEPTH) m_ovf_f = 1;
         if (rd_en_f && q_f.size() == 0) m_udf_f = 1;
         if (r_ok_f) void'(q_f.pop_front());
         if (w_ok_f) q_f.push_back(din_f);
      end
   end

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check_output("std.count", int'(count), q.size());
      check_output("std.empty", int'(empty), int'(q.size() == 0));
      check_output("std.full", int'(full), int'(q.size() == DEPTH));
      check_output("std.almost_full", int'(almost_full), int'(q.size() >= DEPTH - 2));
      check_output("std.almost_empty", int'(almost_empty), int'(q.size() <= 2));
      check_output("std.dout", int'(dout), int'(m_dout));
      check_output("fwft.count", int'(count_f), q_f.size());
      check_output("fwft.empty", int'(empty_f), int'(q_f.size() == 0));
      check_output("fwft.full", int'(full_f), int'(q_f.size() == DEPTH));
      if (q_f.size() > 0) begin
         check_output("fwft.dout", int'(dout_f), int'(q_f[0]));
      end
`ifdef FIFO_FLEX_ERR_EN
      check_output("std.overflow", int'(overflow), int'(m_ovf));
      check_output("std.underflow", int'(underflow), int'(m_udf));
      check_output("fwft.overflow", int'(overflow_f), int'(m_ovf_f));
      check_output("fwft.underflow", int'(underflow_f), int'(m_udf_f));
`endif
   end

   // One clock of requests on the standard instance; returns #1 after the edge.
   task automatic apply_stimulus(input bit w, input bit r, input logic [7:0] d);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic apply_stimulus_fwft(input bit w, input bit r, input logic [7:0] d);
      wr_en_f = w;
      rd_en_f = r;
      din_f   = d;
      @(posedge clk);
      #1;
      wr_en_f = 1'b0;
      rd_en_f = 1'b0;
   endtask

   initial begin
      #1;
      check_output("reset.count", int'(count), 0);
      check_output("reset.empty", int'(empty), 1);
      check_output("reset.almost_empty", int'(almost_empty), 1);
      #11;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill to full, watching the almost_full threshold and the dropped 33rd write.
      for (int i = 0; i < DEPTH; i++) begin
         apply_stimulus(1'b1, 1'b0, 8'(i));
         if (i == 28) check_output("fill.af_at_29", int'(almost_full), 0);
         if (i == 29) check_output("fill.af_at_30", int'(almost_full), 1);
      end
      check_output("fill.full", int'(full), 1);
      check_output("fill.count", int'(count), 32);
      apply_stimulus(1'b1, 1'b0, 8'hAA);
      check_output("fill.drop_count", int'(count), 32);

      // Drain in order, then an extra read at empty must not disturb dout.
      for (int i = 0; i < DEPTH; i++) begin
         apply_stimulus(1'b0, 1'b1, 8'h00);
         check_output("drain.dout", int'(dout), i);
      end
      check_output("drain.empty", int'(empty), 1);
      apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output("drain.extra_dout", int'(dout), 8'h1F);

      // Interleaved bursts across the pointer wrap.
      max_count = 0;
      for (int rep = 0; rep < 4; rep++) begin
         for (int k = 0; k < 30; k++) begin
            apply_stimulus(k < 20, k >= 10, 8'(8'h80 + rep * 20 + k));
            if (int'(count) > max_count) max_count = int'(count);
         end
         for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b0, 1'b1, 8'h00);
         end
         check_output("wrap.last_dout", int'(dout), 8'h80 + rep * 20 + 19);
      end
      check_output("wrap.max_count", max_count, 10);

      // Simultaneous write and read at count 5, at full, at empty.
      for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 8'(8'h40 + i));
      apply_stimulus(1'b1, 1'b1, 8'h45);
      check_output("both5.count", int'(count), 5);
      check_output("both5.dout", int'(dout), 8'h40);
      for (int i = 0; i < 27; i++) apply_stimulus(1'b1, 1'b0, 8'(8'h46 + i));
      check_output("bothfull.pre_full", int'(full), 1);
      apply_stimulus(1'b1, 1'b1, 8'hEE);
      check_output("bothfull.count", int'(count), 31);
      check_output("bothfull.dout", int'(dout), 8'h41);
      for (int i = 0; i < 31; i++) apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output("bothfull.last_dout", int'(dout), 8'h60);
      check_output("bothfull.empty", int'(empty), 1);
      apply_stimulus(1'b1, 1'b1, 8'h77);
      check_output("bothempty.count", int'(count), 1);
      check_output("bothempty.dout", int'(dout), 8'h60);
      apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output("bothempty.pop", int'(dout), 8'h77);

      // FWFT: word appears one cycle after its write edge with no read request.
      apply_stimulus_fwft(1'b1, 1'b0, 8'h5A);
      check_output("fwft.empty_after_wr", int'(empty_f), 0);
      check_output("fwft.dout_5a", int'(dout_f), 8'h5A);
      apply_stimulus_fwft(1'b0, 1'b1, 8'h00);
      check_output("fwft.empty_after_pop", int'(empty_f), 1);

      // Reset mid-stream: outputs must clear without any clock edge.
      for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b0, 8'(8'hC0 + i));
      apply_stimulus(1'b0, 1'b1, 8'h00);
      apply_stimulus(1'b1, 1'b0, 8'hCC);
      check_output("midrst.pre_count", int'(count), 12);
      rst_n = 1'b0;
      #1;
      check_output("midrst.count", int'(count), 0);
      check_output("midrst.empty", int'(empty), 1);
      check_output("midrst.full", int'(full), 0);
      check_output("midrst.almost_empty", int'(almost_empty), 1);
      check_output("midrst.almost_full", int'(almost_full), 0);
      check_output("midrst.dout", int'(dout), 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
`ifdef FIFO_FLEX_ERR_EN
      check_output("err.udf_clear", int'(underflow), 0);
      apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output("err.udf_set", int'(underflow), 1);
      apply_stimulus(1'b0, 1'b0, 8'h00);
      apply_stimulus(1'b0, 1'b0, 8'h00);
      check_output("err.udf_sticky", int'(underflow), 1);
`endif
      apply_stimulus(1'b1, 1'b0, 8'h33);
      check_output("postrst.count", int'(count), 1);
      apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output("postrst.dout", int'(dout), 8'h33);

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
